// File: rtl/logic_unit_and_nand_nor.sv
// Registered bitwise logic unit: AND/NAND/NOR of two operands plus an
// opcode-selected result, all presented one cycle after a valid input.
module logic_unit_and_nand_nor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_result,
  output logic [WIDTH-1:0] nand_result,
  output logic [WIDTH-1:0] nor_result,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;

  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] nand_c;
  logic [WIDTH-1:0] nor_c;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             illegal_c;

  // Next-value logic; the reserved opcode selects all zeros and flags itself.
  always_comb begin
    and_c     = a & b;
    nand_c    = ~(a & b);
    nor_c     = ~(a | b);
    result_c  = '0;
    illegal_c = 1'b0;
    case (op)
      OP_AND:  result_c = and_c;
      OP_NAND: result_c = nand_c;
      OP_NOR:  result_c = nor_c;
      default: illegal_c = 1'b1;
    endcase
    zero_c = (result_c == '0);
  end

  // Output register; data only loads on accepted inputs so idle-cycle X cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      and_result  <= '0;
      nand_result <= '0;
      nor_result  <= '0;
      result      <= '0;
      zero        <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        and_result  <= and_c;
        nand_result <= nand_c;
        nor_result  <= nor_c;
        result      <= result_c;
        zero        <= zero_c;
        illegal_op  <= illegal_c;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_and_nand_nor.sv
// Directed self-checking bench for logic_unit_and_nand_nor (WIDTH = 8).
module tb_logic_unit_and_nand_nor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] and_result;
  logic [WIDTH-1:0] nand_result;
  logic [WIDTH-1:0] nor_result;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal_op;

  int n_checks;
  int n_errors;

  logic_unit_and_nand_nor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .and_result  (and_result),
    .nand_result (nand_result),
    .nor_result  (nor_result),
    .result      (result),
    .zero        (zero),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] e_and;
    logic [7:0] e_nand;
    logic [7:0] e_nor;
    logic [7:0] e_res;
    logic       e_zero;
    logic       e_ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_valid, input vec_t v);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".and"},       32'(and_result), 32'(v.e_and));
    check({tag, ".nand"},      32'(nand_result), 32'(v.e_nand));
    check({tag, ".nor"},       32'(nor_result), 32'(v.e_nor));
    check({tag, ".result"},    32'(result), 32'(v.e_res));
    check({tag, ".zero"},      32'(zero), 32'(v.e_zero));
    check({tag, ".illegal"},   32'(illegal_op), 32'(v.e_ill));
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    op       = v.op;
  endtask

  vec_t zeros;
  vec_t last;

  initial begin
    n_checks = 0;
    n_errors = 0;
    zeros    = '{8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    //            a      b      op     and    nand   nor    res    z     ill
    vecs[0]  = '{8'h0F, 8'hAA, 2'b00, 8'h0A, 8'hF5, 8'h50, 8'h0A, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 8'hAA, 2'b01, 8'hA0, 8'h5F, 8'h05, 8'h5F, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 8'hFF, 8'h2,  8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'hFF, 8'h00, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{8'hAA, 8'h55, 2'b01, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{8'hAA, 8'h55, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'hAA, 8'h55, 2'b10, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'h0F, 8'hAA, 2'b11, 8'h0A, 8'hF5, 8'h50, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h33, 8'h0F, 2'b10, 8'h03, 8'hFC, 8'hC0, 8'hC0, 1'b0, 1'b0};
    vecs[9]  = '{8'h0F, 8'hAA, 2'b01, 8'h0A, 8'hF5, 8'h50, 8'hF5, 1'b0, 1'b0};
    vecs[10] = '{8'hF0, 8'hAA, 2'b10, 8'hA0, 8'h5F, 8'h05, 8'h05, 1'b0, 1'b0};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = 2'b00;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check_all("reset_async", 1'b0, zeros);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("idle_after_reset", 1'b0, zeros);

    // Back-to-back stream of all directed vectors up to the illegal op and beyond
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end
    last = vecs[8];

    // Idle with garbage operands: outputs hold, out_valid drops
    @(negedge clk);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    op       = 2'b11;
    @(posedge clk);
    #1 check_all("hold1", 1'b0, last);
    @(posedge clk);
    #1 check_all("hold2", 1'b0, last);

    // Mid-stream reset discards the in-flight operation
    drive(vecs[9]);
    #2 rst_n = 1'b0;
    #1 check_all("midreset_async", 1'b0, zeros);
    @(posedge clk);
    #1 check_all("midreset_edge", 1'b0, zeros);

    @(negedge clk);
    rst_n = 1'b1;
    drive(vecs[10]);
    @(posedge clk);
    #1 check_all("post_reset_vec", 1'b1, vecs[10]);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_all("pulse_not_sticky", 1'b0, vecs[10]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
